// File: rtl/accumulator_deskew.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : accumulator_deskew                                            |
// | Purpose : Re-aligns the skewed column outputs of a systolic array so    |
// |           that all lanes of a result row appear as one word, then       |
// |           buffers aligned rows in a show-ahead ready/valid FIFO.        |
// | Ports   : clk, reset_n (async, active-low), clear (sync flush)          |
// |           valid_in/raw_cols   : skewed per-column valid and data        |
// |           out_valid/out_ready : output handshake, align_cols = head row |
// |           row_count           : rows accepted into the FIFO (wraps)     |
// |           skew_err/overflow   : sticky fault flags                      |
// |           fifo_level          : current FIFO occupancy                  |
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module accumulator_deskew #(
  parameter int NUM_COLS   = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic [NUM_COLS-1:0]          valid_in,
  input  logic [NUM_COLS*DATA_W-1:0]   raw_cols,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_COLS*DATA_W-1:0]   align_cols,
  output logic [CNT_W-1:0]             row_count,
  output logic                         skew_err,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;
  localparam int ROW_W  = NUM_COLS * DATA_W;

  localparam logic [LVL_W-1:0]    c_full_lvl  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]    c_lvl_one   = LVL_W'(1);
  localparam logic [ADDR_W-1:0]   c_ptr_one   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);
  localparam logic [NUM_COLS-1:0] c_all_valid = '1;

  // Delayed (aligned) valid vector and data row at the alignment point.
  logic [NUM_COLS-1:0] dv;
  logic [ROW_W-1:0]    dd;

  // ---------------------------------------------------------------------
  // Per-lane delay lines: lane k is delayed NUM_COLS-1-k cycles so that it
  // lines up with the last lane, which arrives latest and is used as-is.
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < NUM_COLS - 1; k++) begin : g_lane_dly
    localparam int DEPTH = NUM_COLS - 1 - k;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_d;

    always_comb begin
      data_d[0] = raw_cols[k*DATA_W +: DATA_W];
      vld_d[0]  = valid_in[k];
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_d[i] = '0;
        end
        vld_d = '0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
        vld_q <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign dv[k]                    = vld_q[DEPTH-1];
    assign dd[k*DATA_W +: DATA_W]   = data_q[DEPTH-1];
  end : g_lane_dly

  assign dv[NUM_COLS-1]                         = valid_in[NUM_COLS-1];
  assign dd[(NUM_COLS-1)*DATA_W +: DATA_W]      = raw_cols[(NUM_COLS-1)*DATA_W +: DATA_W];

  // ---------------------------------------------------------------------
  // Aligned-row FIFO and status
  // ---------------------------------------------------------------------
  logic [ROW_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ROW_W-1:0]  mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  row_count_q, row_count_d;
  logic              skew_err_q, skew_err_d;
  logic              overflow_q, overflow_d;
  logic [ROW_W-1:0]  hold_q, hold_d;

  logic row_full;
  logic row_mixed;
  logic pop;
  logic push;

  assign row_full  = (dv == c_all_valid);
  assign row_mixed = (dv != '0) && !row_full;
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the row when the head leaves in the same cycle.
  assign push      = row_full && ((level_q != c_full_lvl) || pop);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    row_count_d = row_count_q;
    skew_err_d  = skew_err_q;
    overflow_d  = overflow_q;
    hold_d      = hold_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      row_count_d = '0;
      skew_err_d  = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dd;
        wr_ptr_d        = wr_ptr_q + c_ptr_one;
        row_count_d     = row_count_q + c_cnt_one;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_one;
        // Keep the departing row visible once the FIFO runs empty.
        hold_d   = mem_q[rd_ptr_q];
      end
      if (push && !pop) begin
        level_d = level_q + c_lvl_one;
      end else if (pop && !push) begin
        level_d = level_q - c_lvl_one;
      end
      if (row_mixed) begin
        skew_err_d = 1'b1;
      end
      if (row_full && !push) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      row_count_q <= '0;
      skew_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
      hold_q      <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      row_count_q <= row_count_d;
      skew_err_q  <= skew_err_d;
      overflow_q  <= overflow_d;
      hold_q      <= hold_d;
    end
  end

  assign align_cols = out_valid ? mem_q[rd_ptr_q] : hold_q;
  assign row_count  = row_count_q;
  assign skew_err   = skew_err_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule : accumulator_deskew
`default_nettype wire
